// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the unified memory port arbiter.
// Source tags mark which requester owns an in-flight read.
package mem_port_arbiter_pkg;

   localparam logic SRC_IF          = 1'b0;
   localparam logic SRC_D           = 1'b1;
   localparam int   MEM_LATENCY_MAX = 4;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_IF   = 2'd1,
      GNT_D    = 2'd2
   } grant_e;

   typedef struct packed {
      logic valid;
      logic src;
   } tag_t;

endpackage

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Fixed-latency {valid, src} shift register that follows reads through the memory.
// A kill strips every IF-tagged stage, including the one presenting its response now.
module resp_tag_pipe
   import mem_port_arbiter_pkg::*;
#(
   parameter int LATENCY = 1
)(
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_src,
   input  logic i_kill_if,
   output logic o_last_valid,
   output logic o_last_src,
   output logic o_busy
);

   tag_t r_tags [LATENCY];
   tag_t w_tags [LATENCY];

   always_comb begin
      o_busy = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         w_tags[i] = r_tags[i];
         if (i_kill_if && (r_tags[i].src == SRC_IF)) begin
            w_tags[i].valid = 1'b0;
         end
         o_busy = o_busy | r_tags[i].valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_tags[i] <= '0;
         end
      end else begin
         r_tags[0] <= tag_t'{valid: i_load, src: i_src};
         for (int i = 1; i < LATENCY; i++) begin
            r_tags[i] <= w_tags[i-1];
         end
      end
   end

   assign o_last_valid = w_tags[LATENCY-1].valid;
   assign o_last_src   = w_tags[LATENCY-1].src;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data wins ties until a pending fetch has been denied STARVE_LIMIT cycles in a row.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AWIDTH       = 32,
   parameter int DWIDTH       = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   input  logic [AWIDTH-1:0]   if_req_addr,
   output logic                if_req_ready,
   output logic                if_resp_valid,
   output logic [DWIDTH-1:0]   if_resp_data,
   input  logic                d_req_valid,
   input  logic                d_req_we,
   input  logic [AWIDTH-1:0]   d_req_addr,
   input  logic [DWIDTH-1:0]   d_req_wdata,
   input  logic [DWIDTH/8-1:0] d_req_wstrb,
   output logic                d_req_ready,
   output logic                d_resp_valid,
   output logic [DWIDTH-1:0]   d_resp_data,
   input  logic                flush,
   output logic                mem_en,
   output logic [DWIDTH/8-1:0] mem_we,
   output logic [AWIDTH-3:0]   mem_addr,
   output logic [DWIDTH-1:0]   mem_wdata,
   input  logic [DWIDTH-1:0]   mem_rdata,
   output logic                busy
);

   localparam int LAT = (MEM_LATENCY < 1) ? 1 :
                        (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;
   localparam int SW  = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   grant_e          w_gnt;
   logic [SW-1:0]   r_starve_cnt;
   logic            w_rd_accept;
   logic            w_rd_src;
   logic            w_last_valid;
   logic            w_last_src;
   logic            w_busy;
   logic            w_unused_addr_lsbs;

   // Readies are forced low during reset so nothing is accepted on the reset edge.
   always_comb begin
      w_gnt = GNT_NONE;
      if (!rst) begin
         if (if_req_valid && d_req_valid) begin
            w_gnt = (r_starve_cnt == STARVE_MAX) ? GNT_IF : GNT_D;
         end else if (if_req_valid) begin
            w_gnt = GNT_IF;
         end else if (d_req_valid) begin
            w_gnt = GNT_D;
         end
      end
   end

   assign if_req_ready = (w_gnt == GNT_IF);
   assign d_req_ready  = (w_gnt == GNT_D);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (w_gnt)
         GNT_IF: begin
            mem_en   = 1'b1;
            mem_addr = if_req_addr[AWIDTH-1:2];
         end
         GNT_D: begin
            mem_en   = 1'b1;
            mem_addr = d_req_addr[AWIDTH-1:2];
            if (d_req_we) begin
               mem_we    = d_req_wstrb;
               mem_wdata = d_req_wdata;
            end
         end
         default: ;
      endcase
   end

   assign w_rd_accept = (w_gnt == GNT_IF) || ((w_gnt == GNT_D) && !d_req_we);
   assign w_rd_src    = (w_gnt == GNT_D) ? SRC_D : SRC_IF;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (if_req_valid && !if_req_ready) begin
         if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end else begin
         r_starve_cnt <= '0;
      end
   end

   resp_tag_pipe #(
      .LATENCY      (LAT)
   ) u_tag_pipe (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_rd_accept),
      .i_src        (w_rd_src),
      .i_kill_if    (flush),
      .o_last_valid (w_last_valid),
      .o_last_src   (w_last_src),
      .o_busy       (w_busy)
   );

   assign if_resp_valid = !rst && w_last_valid && (w_last_src == SRC_IF);
   assign d_resp_valid  = !rst && w_last_valid && (w_last_src == SRC_D);
   assign if_resp_data  = mem_rdata;
   assign d_resp_data   = mem_rdata;
   assign busy          = w_busy;

   // Word-addressed memory: byte-offset bits are intentionally dropped.
   assign w_unused_addr_lsbs = ^{if_req_addr[1:0], d_req_addr[1:0]};

endmodule
